// File: rtl/sm_mem_pkg.sv
// rtl/sm_mem_pkg.sv - shared data memory default widths and request slot type
//
// Purpose : constants and types shared by the SM shared data memory block.
//   DATA_W      default word width
//   MEM_AW      default memory address bits (depth 2^MEM_AW words)
//   req_slot_t  one latched core request {we, addr, wdata} at default widths
package sm_mem_pkg;

    localparam int DATA_W = 16;
    localparam int MEM_AW = 8;

    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_slot_t;

endpackage

// File: rtl/sm_shared_data_mem_rr_arbiter.sv
// rtl/sm_shared_data_mem_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose : picks one requester, searching upward from ptr with wrap.
// Ports   :
//   req        in   N       request vector
//   ptr        in   PTR_W   index where the search starts
//   grant      out  N       one-hot winner (all zero when nothing requests)
//   grant_idx  out  PTR_W   binary index of the winner (0 when no grant)
//   any_grant  out  1       some request won
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            // Candidate index ptr+i folded back into 0..N-1 (N need not be a power of two).
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_grant && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_shared_data_mem.sv
// rtl/sm_shared_data_mem.sv - per-core request slots, round-robin single-port word memory
//
// Purpose : services SP core loads/stores of one SM. Each core's one-cycle
//           request is latched in its slot, slots are served round-robin, one
//           access per cycle, with a one-cycle response pulse.
// Ports   :
//   clk         in   1                 clock
//   reset       in   1                 asynchronous active-low reset
//   req_valid   in   N_CORES           per-core request strobe
//   req_we      in   N_CORES           1 = store, 0 = load
//   req_addr    in   N_CORES*ADDR_W    core k at [k*ADDR_W +: ADDR_W]
//   req_wdata   in   N_CORES*DATA_W    core k at [k*DATA_W +: DATA_W]
//   resp_valid  out  N_CORES           one-hot completion pulse
//   resp_rdata  out  DATA_W            load data (store data echoed for stores)
//   busy        out  N_CORES           request pending per core
//   overrun     out  N_CORES           sticky: request dropped while one was pending
module sm_shared_data_mem
    import sm_mem_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int DATA_W  = sm_mem_pkg::DATA_W,
    parameter int MEM_AW  = sm_mem_pkg::MEM_AW,
    parameter int ADDR_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        req_valid,
    input  logic [N_CORES-1:0]        req_we,
    input  logic [N_CORES*ADDR_W-1:0] req_addr,
    input  logic [N_CORES*DATA_W-1:0] req_wdata,
    output logic [N_CORES-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic [N_CORES-1:0]        busy,
    output logic [N_CORES-1:0]        overrun
);

    localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    // Same layout as req_slot_t, but sized by this instance's parameters.
    typedef struct packed {
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    slot_t              slot [N_CORES];
    logic [N_CORES-1:0] pend;
    logic [PTR_W-1:0]   ptr;
    logic [DATA_W-1:0]  mem [2**MEM_AW];

    logic [N_CORES-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               any_grant;
    slot_t              gslot;
    logic [PTR_W-1:0]   ptr_next;

    rr_arbiter #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_arb (
        .req       (pend),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign gslot    = slot[grant_idx];
    assign ptr_next = (grant_idx == PTR_W'(N_CORES - 1)) ? '0 : grant_idx + 1'b1;
    assign busy     = pend;

    // Address bits above MEM_AW are discarded, so addresses alias modulo the depth.
    generate
        if (ADDR_W > MEM_AW) begin : g_addr_hi
            for (genvar k = 0; k < N_CORES; k++) begin : g_core
                logic unused_addr_hi;
                assign unused_addr_hi = ^req_addr[k*ADDR_W+MEM_AW +: ADDR_W-MEM_AW];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend       <= '0;
            ptr        <= '0;
            overrun    <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            for (int k = 0; k < N_CORES; k++) begin
                slot[k] <= '0;
            end
        end else begin
            resp_valid <= any_grant ? grant : '0;
            if (any_grant) begin
                ptr        <= ptr_next;
                resp_rdata <= gslot.we ? gslot.wdata : mem[gslot.addr];
            end
            for (int k = 0; k < N_CORES; k++) begin
                // A slot being served this cycle frees up at the edge, so a new
                // request arriving now can take it without an overrun.
                if (req_valid[k] && (!pend[k] || grant[k])) begin
                    slot[k].we    <= req_we[k];
                    slot[k].addr  <= req_addr[k*ADDR_W +: MEM_AW];
                    slot[k].wdata <= req_wdata[k*DATA_W +: DATA_W];
                    pend[k]       <= 1'b1;
                end else if (req_valid[k]) begin
                    overrun[k] <= 1'b1;
                end else if (grant[k]) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    // Memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (any_grant && gslot.we) begin
            mem[gslot.addr] <= gslot.wdata;
        end
    end

endmodule

// File: tb/tb_sm_shared_data_mem.sv
// tb/tb_sm_shared_data_mem.sv - directed self-checking bench for sm_shared_data_mem
module tb_sm_shared_data_mem;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_rdata;
    logic [N-1:0]    busy;
    logic [N-1:0]    overrun;

    int n_cmp = 0;
    int n_bad = 0;

    sm_shared_data_mem #(
        .N_CORES (N),
        .DATA_W  (DW),
        .MEM_AW  (8),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        req_valid[k]          = 1'b1;
        req_we[k]             = we;
        req_addr[k*AW +: AW]  = addr;
        req_wdata[k*DW +: DW] = wdata;
    endtask

    task automatic clr_req();
        req_valid = '0;
        req_we    = '0;
    endtask

    initial begin
        logic [3:0] busy_seq [5];
        busy_seq[0] = 4'b1110;
        busy_seq[1] = 4'b1100;
        busy_seq[2] = 4'b1000;
        busy_seq[3] = 4'b0000;
        busy_seq[4] = 4'b0000;

        // Reset state
        tick();
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", 32'(resp_rdata), 32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_overrun",    32'(overrun),    32'h0);
        reset = 1'b1;
        tick();

        // Store then load, core 0
        set_req(0, 1'b1, 16'h0012, 16'hBEEF);
        tick();
        check("st0_busy_e0",  32'(busy),       32'h1);
        check("st0_resp_e0",  32'(resp_valid), 32'h0);
        clr_req();
        tick();
        check("st0_resp_e1",  32'(resp_valid), 32'h1);
        check("st0_rdata",    32'(resp_rdata), 32'hBEEF);
        check("st0_busy_e1",  32'(busy),       32'h0);
        set_req(0, 1'b0, 16'h0012, 16'h0000);
        tick();
        check("ld0_resp_e0",  32'(resp_valid), 32'h0);
        clr_req();
        tick();
        check("ld0_resp_e1",  32'(resp_valid), 32'h1);
        check("ld0_rdata",    32'(resp_rdata), 32'hBEEF);

        // Address wrap on core 3 (also leaves ptr at 0)
        set_req(3, 1'b1, 16'h0105, 16'h1234);
        tick();
        clr_req();
        tick();
        check("wrap_st_resp", 32'(resp_valid), 32'h8);
        set_req(3, 1'b0, 16'h0005, 16'h0000);
        tick();
        clr_req();
        tick();
        check("wrap_ld_resp",  32'(resp_valid), 32'h8);
        check("wrap_ld_rdata", 32'(resp_rdata), 32'h1234);

        // All four cores store together, then all four load together
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 16'h0020 + 16'(k), 16'hA000 + 16'(k));
        tick();
        check("all_st_busy", 32'(busy), 32'hF);
        clr_req();
        for (int k = 0; k < N; k++) begin
            tick();
            check($sformatf("all_st_resp%0d", k),  32'(resp_valid), 32'(1 << k));
            check($sformatf("all_st_rdata%0d", k), 32'(resp_rdata), 32'hA000 + 32'(k));
        end
        tick();
        check("all_st_idle", 32'(resp_valid), 32'h0);

        for (int k = 0; k < N; k++) set_req(k, 1'b0, 16'h0020 + 16'(k), 16'h0000);
        tick();
        check("all_ld_busy", 32'(busy), 32'hF);
        clr_req();
        for (int k = 0; k < N; k++) begin
            tick();
            check($sformatf("all_ld_resp%0d", k),  32'(resp_valid), 32'(1 << k));
            check($sformatf("all_ld_rdata%0d", k), 32'(resp_rdata), 32'hA000 + 32'(k));
            check($sformatf("all_ld_busy%0d", k),  32'(busy),       32'(busy_seq[k]));
        end
        tick();
        check("all_ld_idle", 32'(resp_valid), 32'h0);

        // Fairness: grants go 0,2,0
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        set_req(2, 1'b0, 16'h0022, 16'h0000);
        tick();
        check("fair_busy0", 32'(busy), 32'h5);
        clr_req();
        tick();
        check("fair_g0_resp",  32'(resp_valid), 32'h1);
        check("fair_g0_rdata", 32'(resp_rdata), 32'hA000);
        check("fair_busy1",    32'(busy),       32'h4);
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        tick();
        clr_req();
        check("fair_g1_resp",  32'(resp_valid), 32'h4);
        check("fair_g1_rdata", 32'(resp_rdata), 32'hA002);
        check("fair_busy2",    32'(busy),       32'h1);
        tick();
        check("fair_g2_resp",  32'(resp_valid), 32'h1);
        check("fair_g2_rdata", 32'(resp_rdata), 32'hA000);

        // Core 3 access brings ptr back to 0
        set_req(3, 1'b0, 16'h0023, 16'h0000);
        tick();
        clr_req();
        tick();
        check("ptr_fix_rdata", 32'(resp_rdata), 32'hA003);

        // Overrun: core 1 re-requests while core 0 is being served
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        set_req(1, 1'b0, 16'h0021, 16'h0000);
        tick();
        check("ovr_busy0", 32'(busy), 32'h3);
        clr_req();
        set_req(1, 1'b0, 16'h0023, 16'h0000);
        tick();
        clr_req();
        check("ovr_resp0",    32'(resp_valid), 32'h1);
        check("ovr_rdata0",   32'(resp_rdata), 32'hA000);
        check("ovr_flag",     32'(overrun),    32'h2);
        check("ovr_busy1",    32'(busy),       32'h2);
        tick();
        check("ovr_resp1",    32'(resp_valid), 32'h2);
        check("ovr_rdata1",   32'(resp_rdata), 32'hA001);
        check("ovr_busy2",    32'(busy),       32'h0);
        tick();
        check("ovr_no_extra", 32'(resp_valid), 32'h0);
        check("ovr_sticky",   32'(overrun),    32'h2);

        // Reset mid-operation with three requests pending
        set_req(0, 1'b0, 16'h0020, 16'h0000);
        set_req(1, 1'b0, 16'h0021, 16'h0000);
        set_req(2, 1'b0, 16'h0022, 16'h0000);
        tick();
        clr_req();
        check("mid_busy_pre", 32'(busy), 32'h7);
        reset = 1'b0;
        #1;
        check("mid_busy",    32'(busy),       32'h0);
        check("mid_overrun", 32'(overrun),    32'h0);
        check("mid_resp",    32'(resp_valid), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("post_resp", 32'(resp_valid), 32'h0);
        check("post_busy", 32'(busy),       32'h0);
        set_req(2, 1'b1, 16'h0030, 16'h5A5A);
        tick();
        clr_req();
        check("post_st_busy",  32'(busy),       32'h4);
        tick();
        check("post_st_resp",  32'(resp_valid), 32'h4);
        set_req(2, 1'b0, 16'h0030, 16'h0000);
        tick();
        clr_req();
        tick();
        check("post_ld_resp",  32'(resp_valid), 32'h4);
        check("post_ld_rdata", 32'(resp_rdata), 32'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
